// File: rtl/ex2_hilo.sv
// Second execute stage: registers the EX1 result/control into the EX2/MEM boundary
// and owns the HI/LO accumulator, including the two-cycle multiply-accumulate/subtract.
module ex2_hilo (
  input  logic        Clock,
  input  logic        nReset,
  input  logic        ValidIn,
  input  logic        Stall,
  input  logic        Flush,
  input  logic [63:0] In,
  input  logic        ACCEn,
  input  logic [2:0]  AccOp,
  input  logic        RegWriteIn,
  input  logic        MemReadIn,
  input  logic        MemtoRegIn,
  input  logic        MemWriteIn,
  input  logic [4:0]  RAddrIn,
  input  logic [2:0]  MemfuncIn,
  input  logic [31:0] RtDataIn,
  output logic [31:0] Out,
  output logic        ValidOut,
  output logic        RegWriteOut,
  output logic        MemReadOut,
  output logic        MemtoRegOut,
  output logic        MemWriteOut,
  output logic [4:0]  RAddrOut,
  output logic [2:0]  MemfuncOut,
  output logic [31:0] RtDataOut,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACC_HI = 1'b1
  } state_t;

  localparam logic [2:0] OP_MULT = 3'd1;
  localparam logic [2:0] OP_MADD = 3'd2;
  localparam logic [2:0] OP_MSUB = 3'd3;
  localparam logic [2:0] OP_MTHI = 3'd4;
  localparam logic [2:0] OP_MTLO = 3'd5;
  localparam logic [2:0] OP_MFHI = 3'd6;
  localparam logic [2:0] OP_MFLO = 3'd7;

  state_t      state_q, state_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        carry_q, carry_d;
  logic [31:0] high_q, high_d;
  logic        sub_q, sub_d;

  logic [31:0] out_q, out_d;
  logic        valid_q, valid_d;
  logic        regw_q, regw_d;
  logic        memr_q, memr_d;
  logic        m2r_q, m2r_d;
  logic        memw_q, memw_d;
  logic [4:0]  raddr_q, raddr_d;
  logic [2:0]  mfunc_q, mfunc_d;
  logic [31:0] rtdata_q, rtdata_d;

  logic        accept_s;
  logic        op_s;
  logic [32:0] lo_add_s;
  logic [32:0] lo_sub_s;
  logic [31:0] hi_add_s;
  logic [31:0] hi_sub_s;

  assign accept_s = ValidIn & ~Flush & ~Stall & (state_q == IDLE);
  assign op_s     = accept_s & ACCEn;

  // Bit 32 of the subtraction is the borrow out of the low half.
  assign lo_add_s = {1'b0, lo_q} + {1'b0, In[31:0]};
  assign lo_sub_s = {1'b0, lo_q} - {1'b0, In[31:0]};
  assign hi_add_s = hi_q + high_q + {31'd0, carry_q};
  assign hi_sub_s = hi_q - high_q - {31'd0, carry_q};

  always_comb begin
    state_d  = state_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    carry_d  = carry_q;
    high_d   = high_q;
    sub_d    = sub_q;
    out_d    = out_q;
    valid_d  = valid_q;
    regw_d   = regw_q;
    memr_d   = memr_q;
    m2r_d    = m2r_q;
    memw_d   = memw_q;
    raddr_d  = raddr_q;
    mfunc_d  = mfunc_q;
    rtdata_d = rtdata_q;

    if (!Stall) begin
      case (state_q)
        IDLE: begin
          if (op_s) begin
            case (AccOp)
              OP_MULT: begin
                hi_d = In[63:32];
                lo_d = In[31:0];
              end
              OP_MADD: begin
                lo_d    = lo_add_s[31:0];
                carry_d = lo_add_s[32];
                high_d  = In[63:32];
                sub_d   = 1'b0;
                state_d = ACC_HI;
              end
              OP_MSUB: begin
                lo_d    = lo_sub_s[31:0];
                carry_d = lo_sub_s[32];
                high_d  = In[63:32];
                sub_d   = 1'b1;
                state_d = ACC_HI;
              end
              OP_MTHI: hi_d = In[31:0];
              OP_MTLO: lo_d = In[31:0];
              default: hi_d = hi_q;
            endcase
          end else begin
            state_d = IDLE;
          end
        end
        ACC_HI: begin
          hi_d    = sub_q ? hi_sub_s : hi_add_s;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase

      if (accept_s) begin
        if (ACCEn && (AccOp == OP_MFHI)) begin
          out_d = hi_q;
        end else if (ACCEn && (AccOp == OP_MFLO)) begin
          out_d = lo_q;
        end else begin
          out_d = In[31:0];
        end
        valid_d  = 1'b1;
        regw_d   = RegWriteIn;
        memr_d   = MemReadIn;
        m2r_d    = MemtoRegIn;
        memw_d   = MemWriteIn;
        raddr_d  = RAddrIn;
        mfunc_d  = MemfuncIn;
        rtdata_d = RtDataIn;
      end else begin
        out_d    = 32'd0;
        valid_d  = 1'b0;
        regw_d   = 1'b0;
        memr_d   = 1'b0;
        m2r_d    = 1'b0;
        memw_d   = 1'b0;
        raddr_d  = 5'd0;
        mfunc_d  = 3'd0;
        rtdata_d = 32'd0;
      end
    end else begin
      state_d = state_q;
    end
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q  <= IDLE;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      carry_q  <= 1'b0;
      high_q   <= 32'd0;
      sub_q    <= 1'b0;
      out_q    <= 32'd0;
      valid_q  <= 1'b0;
      regw_q   <= 1'b0;
      memr_q   <= 1'b0;
      m2r_q    <= 1'b0;
      memw_q   <= 1'b0;
      raddr_q  <= 5'd0;
      mfunc_q  <= 3'd0;
      rtdata_q <= 32'd0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      carry_q  <= carry_d;
      high_q   <= high_d;
      sub_q    <= sub_d;
      out_q    <= out_d;
      valid_q  <= valid_d;
      regw_q   <= regw_d;
      memr_q   <= memr_d;
      m2r_q    <= m2r_d;
      memw_q   <= memw_d;
      raddr_q  <= raddr_d;
      mfunc_q  <= mfunc_d;
      rtdata_q <= rtdata_d;
    end
  end

  assign Out         = out_q;
  assign ValidOut    = valid_q;
  assign RegWriteOut = regw_q;
  assign MemReadOut  = memr_q;
  assign MemtoRegOut = m2r_q;
  assign MemWriteOut = memw_q;
  assign RAddrOut    = raddr_q;
  assign MemfuncOut  = mfunc_q;
  assign RtDataOut   = rtdata_q;
  assign Busy        = (state_q == ACC_HI);
  assign HI          = hi_q;
  assign LO          = lo_q;

endmodule

// File: tb/tb_ex2_hilo.sv
// Scoreboard bench for ex2_hilo: a 64-bit accumulator model predicts every output
// bundle; a negedge monitor pops and compares whatever the DUT presents.
module tb_ex2_hilo;

  logic        Clock = 1'b0;
  logic        nReset = 1'b0;
  logic        ValidIn = 1'b0, Stall = 1'b0, Flush = 1'b0, ACCEn = 1'b0;
  logic [63:0] In = 64'd0;
  logic [2:0]  AccOp = 3'd0;
  logic        RegWriteIn = 1'b0, MemReadIn = 1'b0, MemtoRegIn = 1'b0, MemWriteIn = 1'b0;
  logic [4:0]  RAddrIn = 5'd0;
  logic [2:0]  MemfuncIn = 3'd0;
  logic [31:0] RtDataIn = 32'd0;
  logic [31:0] Out, RtDataOut, HI, LO;
  logic        ValidOut, RegWriteOut, MemReadOut, MemtoRegOut, MemWriteOut, Busy;
  logic [4:0]  RAddrOut;
  logic [2:0]  MemfuncOut;

  ex2_hilo dut (
    .Clock(Clock), .nReset(nReset), .ValidIn(ValidIn), .Stall(Stall), .Flush(Flush),
    .In(In), .ACCEn(ACCEn), .AccOp(AccOp),
    .RegWriteIn(RegWriteIn), .MemReadIn(MemReadIn), .MemtoRegIn(MemtoRegIn), .MemWriteIn(MemWriteIn),
    .RAddrIn(RAddrIn), .MemfuncIn(MemfuncIn), .RtDataIn(RtDataIn),
    .Out(Out), .ValidOut(ValidOut),
    .RegWriteOut(RegWriteOut), .MemReadOut(MemReadOut), .MemtoRegOut(MemtoRegOut), .MemWriteOut(MemWriteOut),
    .RAddrOut(RAddrOut), .MemfuncOut(MemfuncOut), .RtDataOut(RtDataOut),
    .Busy(Busy), .HI(HI), .LO(LO)
  );

  always #5 Clock = ~Clock;

  typedef struct packed {
    logic        valid;
    logic [31:0] out;
    logic        regw, memr, m2r, memw;
    logic [4:0]  raddr;
    logic [2:0]  mfunc;
    logic [31:0] rt;
  } exp_t;

  typedef struct {
    logic        v, f, s, en;
    logic [2:0]  op;
    logic [63:0] in;
    logic        regw, memr, m2r, memw;
    logic [4:0]  raddr;
    logic [2:0]  mfunc;
    logic [31:0] rt;
  } stim_t;

  exp_t exp_q[$];
  exp_t last_exp = '0;
  exp_t mon_e;
  exp_t act_e;
  logic hold_edge = 1'b1;

  // Behavioural model: a single 64-bit accumulator plus "HI still pending" state.
  logic [63:0] m_acc = 64'd0;
  logic [31:0] m_hi_old = 32'd0;
  logic        m_busy = 1'b0;

  int checks = 0;
  int passed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act === expv) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  function automatic stim_t mk(input logic v, input logic f, input logic s, input logic en,
                               input logic [2:0] op, input logic [63:0] in);
    stim_t st;
    st.v = v; st.f = f; st.s = s; st.en = en; st.op = op; st.in = in;
    st.regw = 1'($urandom); st.memr = 1'($urandom); st.m2r = 1'($urandom); st.memw = 1'($urandom);
    st.raddr = 5'($urandom); st.mfunc = 3'($urandom); st.rt = $urandom;
    return st;
  endfunction

  task automatic model_step(input stim_t st);
    exp_t e;
    if (st.s) begin
      hold_edge = 1'b1;
    end else begin
      hold_edge = 1'b0;
      e = '0;
      if (m_busy) begin
        m_busy = 1'b0;
      end else if (st.v && !st.f) begin
        e.valid = 1'b1;
        e.out = (st.en && st.op == 3'd6) ? m_acc[63:32] :
                (st.en && st.op == 3'd7) ? m_acc[31:0] : st.in[31:0];
        e.regw = st.regw; e.memr = st.memr; e.m2r = st.m2r; e.memw = st.memw;
        e.raddr = st.raddr; e.mfunc = st.mfunc; e.rt = st.rt;
        if (st.en) begin
          case (st.op)
            3'd1: m_acc = st.in;
            3'd2: begin m_hi_old = m_acc[63:32]; m_acc = m_acc + st.in; m_busy = 1'b1; end
            3'd3: begin m_hi_old = m_acc[63:32]; m_acc = m_acc - st.in; m_busy = 1'b1; end
            3'd4: m_acc[63:32] = st.in[31:0];
            3'd5: m_acc[31:0] = st.in[31:0];
            default: ;
          endcase
        end
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic cyc(input stim_t st);
    ValidIn = st.v; Flush = st.f; Stall = st.s; ACCEn = st.en; AccOp = st.op; In = st.in;
    RegWriteIn = st.regw; MemReadIn = st.memr; MemtoRegIn = st.m2r; MemWriteIn = st.memw;
    RAddrIn = st.raddr; MemfuncIn = st.mfunc; RtDataIn = st.rt;
    @(posedge Clock);
    model_step(st);
    @(negedge Clock);
    #1;
  endtask

  task automatic idle();
    cyc(mk(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 64'd0));
  endtask

  task automatic do_reset();
    #1 nReset = 1'b0;
    #1;
    chk("rst_out", {32'd0, Out}, 64'd0);
    chk("rst_ctrl", {58'd0, ValidOut, RegWriteOut, MemReadOut, MemtoRegOut, MemWriteOut, Busy}, 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    chk("rst_pass", {24'd0, RAddrOut, MemfuncOut, RtDataOut}, 64'd0);
    m_acc = 64'd0; m_busy = 1'b0; m_hi_old = 32'd0;
    exp_q.delete(); last_exp = '0; hold_edge = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    #2 nReset = 1'b1;
  endtask

  // Monitor: checks accumulator state every cycle and the output bundle on every new edge.
  always @(negedge Clock) begin
    chk("hilo_busy", {HI, LO}, {(m_busy ? m_hi_old : m_acc[63:32]), m_acc[31:0]});
    chk("busy", {63'd0, Busy}, {63'd0, m_busy});
    act_e = '{ValidOut, Out, RegWriteOut, MemReadOut, MemtoRegOut, MemWriteOut,
              RAddrOut, MemfuncOut, RtDataOut};
    if (!hold_edge) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL outq: DUT presented output but scoreboard empty");
      end else begin
        mon_e = exp_q.pop_front();
        last_exp = mon_e;
        chk("out_bundle", 64'(act_e[107:44]), 64'(mon_e[107:44]));
        chk("out_tail", 64'(act_e[43:0]), 64'(mon_e[43:0]));
      end
    end else begin
      chk("frozen_bundle", 64'(act_e[107:44]), 64'(last_exp[107:44]));
    end
  end

  initial begin
    nReset = 1'b0;
    repeat (2) @(negedge Clock);
    #2 nReset = 1'b1;

    // ALU passthrough after reset
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd0, 64'h0000_0000_1234_5678));
    chk("alu_out", {32'd0, Out}, 64'h1234_5678);
    chk("alu_valid", {63'd0, ValidOut}, 64'd1);

    // MULT then MADD with carry
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 64'h0000_0001_FFFF_FFFF));
    chk("mult_hilo", {HI, LO}, 64'h0000_0001_FFFF_FFFF);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 64'd1));
    chk("madd_e1", {31'd0, Busy, LO}, {31'd0, 1'b1, 32'd0});
    idle();
    chk("madd_e2", {31'd0, Busy, HI}, {31'd0, 1'b0, 32'h2});

    // MSUB borrow, MADD wrap
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 64'h0000_0002_0000_0000));
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 64'd1));
    idle();
    chk("msub_borrow", {HI, LO}, 64'h0000_0001_FFFF_FFFF);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF));
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 64'd1));
    idle();
    chk("madd_wrap", {HI, LO}, 64'd0);

    // MADD followed by MFHI held by upstream while Busy
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 64'h0000_0005_0000_0007));
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 64'h0000_0003_0000_0010));
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 64'd0));
    chk("hold_bubble", {63'd0, ValidOut}, 64'd0);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd6, 64'd0));
    chk("mfhi_after_madd", {31'd0, ValidOut, Out}, {31'd0, 1'b1, 32'h8});

    // Stall held in ACC_HI
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 64'h0000_0000_0000_0001));
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 64'h0000_0001_FFFF_FFFF));
    for (int i = 0; i < 3; i++) begin
      cyc(mk(1'b1, 1'b0, 1'b1, 1'b1, 3'd1, 64'hABCD));
      chk("stall_hold", {31'd0, Busy, HI}, {31'd0, 1'b1, 32'd0});
    end
    idle();
    chk("stall_release", {31'd0, Busy, HI}, {31'd0, 1'b0, 32'h2});

    // Flush on an IDLE instruction, then flush during ACC_HI
    cyc(mk(1'b1, 1'b1, 1'b0, 1'b1, 3'd5, 64'hDEAD));
    chk("flush_mtlo", {31'd0, ValidOut, LO}, 64'd0);
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd1, 64'h0000_0000_FFFF_FFFF));
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 64'h0000_0002_0000_0001));
    cyc(mk(1'b1, 1'b1, 1'b0, 1'b1, 3'd6, 64'd0));
    chk("flush_in_acc", {31'd0, ValidOut, HI}, {31'd0, 1'b0, 32'h3});

    // ACCEn=0 with MFHI returns In and leaves HI/LO alone
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b0, 3'd6, 64'h0000_0000_CAFE_F00D));
    chk("accen_off", {Out, HI}, {32'hCAFE_F00D, 32'h3});

    // Async reset in the middle of an accumulate
    cyc(mk(1'b1, 1'b0, 1'b0, 1'b1, 3'd3, 64'h0000_0001_0000_0005));
    do_reset();
    idle();
    chk("post_reset_hilo", {HI, LO}, 64'd0);

    // Randomised traffic
    for (int i = 0; i < 500; i++) begin
      cyc(mk(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) < 1),
             1'($urandom_range(0, 9) < 1), 1'($urandom_range(0, 9) < 9),
             3'($urandom), {$urandom, $urandom}));
    end
    repeat (3) idle();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
